// File: rtl/pipeline_hazard_controller_if.sv
// Purpose: bundles the hazard controller's decode-side inputs and pipeline-control outputs.
// Latency: n/a (signal bundle only).
// Backpressure: n/a; stall outputs are the pipeline's backpressure, dmemReady is the memory's.
// Ports (slave = controller view):
//   in : idRs1/idRs2, idUsesRs1/idUsesRs2, exRs1/exRs2, exRd, exMemoryReadEnable,
//        exPcUpdateTaken, memRd, memRegisterWriteEnable, memAccess, dmemReady,
//        wbRd, wbRegisterWriteEnable
//   out: stallFetch/Decode/Execute/Memory, flushDecode/Execute, forwardA/B, memTimeout
//   out (HAZARD_PERF_COUNTERS_EN only): stallCycleCount, flushCount
interface pipeline_hazard_controller_if
`ifdef HAZARD_PERF_COUNTERS_EN
    #(parameter int CNT_W = 32)
`endif
    ;
    logic [4:0] idRs1;
    logic [4:0] idRs2;
    logic       idUsesRs1;
    logic       idUsesRs2;
    logic [4:0] exRs1;
    logic [4:0] exRs2;
    logic [4:0] exRd;
    logic       exMemoryReadEnable;
    logic       exPcUpdateTaken;
    logic [4:0] memRd;
    logic       memRegisterWriteEnable;
    logic       memAccess;
    logic       dmemReady;
    logic [4:0] wbRd;
    logic       wbRegisterWriteEnable;

    logic       stallFetch;
    logic       stallDecode;
    logic       stallExecute;
    logic       stallMemory;
    logic       flushDecode;
    logic       flushExecute;
    logic [1:0] forwardA;
    logic [1:0] forwardB;
    logic       memTimeout;
`ifdef HAZARD_PERF_COUNTERS_EN
    logic [CNT_W-1:0] stallCycleCount;
    logic [CNT_W-1:0] flushCount;
`endif

    modport master (
        output idRs1, idRs2, idUsesRs1, idUsesRs2,
        output exRs1, exRs2, exRd, exMemoryReadEnable, exPcUpdateTaken,
        output memRd, memRegisterWriteEnable, memAccess, dmemReady,
        output wbRd, wbRegisterWriteEnable,
`ifdef HAZARD_PERF_COUNTERS_EN
        input  stallCycleCount, flushCount,
`endif
        input  stallFetch, stallDecode, stallExecute, stallMemory,
        input  flushDecode, flushExecute, forwardA, forwardB, memTimeout
    );

    modport slave (
        input  idRs1, idRs2, idUsesRs1, idUsesRs2,
        input  exRs1, exRs2, exRd, exMemoryReadEnable, exPcUpdateTaken,
        input  memRd, memRegisterWriteEnable, memAccess, dmemReady,
        input  wbRd, wbRegisterWriteEnable,
`ifdef HAZARD_PERF_COUNTERS_EN
        output stallCycleCount, flushCount,
`endif
        output stallFetch, stallDecode, stallExecute, stallMemory,
        output flushDecode, flushExecute, forwardA, forwardB, memTimeout
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Purpose: 5-stage pipeline hazard control: load-use stall, redirect flush, EX forwarding,
//          data-memory wait freeze with sticky timeout trap.
// Latency: stall/flush/forward outputs are combinational in the same cycle; memTimeout is registered.
// Backpressure: a pending dmem access (memAccess && !dmemReady) freezes every stage until dmemReady.
// Ports: clock, reset (synchronous, active-high; forces every output to 0 while high),
//        bus (pipeline_hazard_controller_if.slave) carrying all decode inputs and control outputs.
// Optional feature: define HAZARD_PERF_COUNTERS_EN to add saturating stallCycleCount/flushCount.
module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    pipeline_hazard_controller_if.slave   bus
);

    localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WC_W-1:0] waitCount_q, waitCount_d;
    logic            memTimeout_q, memTimeout_d;

    logic memWait;
    logic loadUse;
    logic stall_all;    // freezes every stage
    logic stall_front;  // holds PC and IF/ID only (load-use bubble)
    logic flush_dec;
    logic flush_exe;

    // MEM result is newer than WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(
        input logic       mem_we,
        input logic [4:0] mem_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd,
        input logic [4:0] rs
    );
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
            return 2'b10;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    always_comb begin
        memWait = bus.memAccess && !bus.dmemReady;
        loadUse = bus.exMemoryReadEnable && (bus.exRd != 5'd0) &&
                  ((bus.idUsesRs1 && (bus.idRs1 == bus.exRd)) ||
                   (bus.idUsesRs2 && (bus.idRs2 == bus.exRd)));

        stall_all    = 1'b0;
        stall_front  = 1'b0;
        flush_dec    = 1'b0;
        flush_exe    = 1'b0;
        state_d      = state_q;
        waitCount_d  = waitCount_q;
        memTimeout_d = memTimeout_q;

        case (state_q)
            RUN: begin
                if (memWait) begin
                    stall_all   = 1'b1;
                    waitCount_d = WC_W'(1);
                    state_d     = MEM_WAIT;
                end else if (bus.exPcUpdateTaken) begin
                    // The ID instruction is squashed by the redirect, so its load-use is moot.
                    flush_dec = 1'b1;
                    flush_exe = 1'b1;
                end else if (loadUse) begin
                    stall_front = 1'b1;
                    flush_exe   = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Completion (dmemReady, or memAccess withdrawn) releases the stall in the
                // same cycle; any redirect/load-use held in EX is handled on the next RUN cycle.
                if (!memWait) begin
                    waitCount_d = '0;
                    state_d     = RUN;
                end else begin
                    stall_all = 1'b1;
                    if (waitCount_q == WC_LAST) begin
                        state_d      = TIMEOUT;
                        memTimeout_d = 1'b1;
                    end else begin
                        waitCount_d = waitCount_q + WC_W'(1);
                    end
                end
            end
            TIMEOUT: begin
                stall_all = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= RUN;
            waitCount_q  <= '0;
            memTimeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            waitCount_q  <= waitCount_d;
            memTimeout_q <= memTimeout_d;
        end
    end

    // Reset gates every output, including the purely combinational ones.
    assign bus.stallFetch   = !reset && (stall_all || stall_front);
    assign bus.stallDecode  = !reset && (stall_all || stall_front);
    assign bus.stallExecute = !reset && stall_all;
    assign bus.stallMemory  = !reset && stall_all;
    assign bus.flushDecode  = !reset && flush_dec;
    assign bus.flushExecute = !reset && flush_exe;
    assign bus.memTimeout   = !reset && memTimeout_q;
    assign bus.forwardA     = reset ? 2'b00 :
        fwd_sel(bus.memRegisterWriteEnable, bus.memRd, bus.wbRegisterWriteEnable, bus.wbRd, bus.exRs1);
    assign bus.forwardB     = reset ? 2'b00 :
        fwd_sel(bus.memRegisterWriteEnable, bus.memRd, bus.wbRegisterWriteEnable, bus.wbRd, bus.exRs2);

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [CNT_W-1:0] stallCycleCount_q;
    logic [CNT_W-1:0] flushCount_q;

    // Both counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            stallCycleCount_q <= '0;
            flushCount_q      <= '0;
        end else begin
            if (bus.stallFetch && (stallCycleCount_q != '1)) begin
                stallCycleCount_q <= stallCycleCount_q + CNT_W'(1);
            end
            if ((bus.flushDecode || bus.flushExecute) && (flushCount_q != '1)) begin
                flushCount_q <= flushCount_q + CNT_W'(1);
            end
        end
    end

    assign bus.stallCycleCount = reset ? '0 : stallCycleCount_q;
    assign bus.flushCount      = reset ? '0 : flushCount_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 32;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    pipeline_hazard_controller_if hif();

    pipeline_hazard_controller #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (hif)
    );

    typedef struct {
        logic       rst;
        logic [4:0] idRs1, idRs2;
        logic       idUsesRs1, idUsesRs2;
        logic [4:0] exRs1, exRs2, exRd;
        logic       exMemoryReadEnable, exPcUpdateTaken;
        logic [4:0] memRd;
        logic       memRegisterWriteEnable, memAccess, dmemReady;
        logic [4:0] wbRd;
        logic       wbRegisterWriteEnable;
    } stim_t;

    typedef struct packed {
        logic        sf, sd, se, sm, fd, fe;
        logic [1:0]  fa, fb;
        logic        to;
        logic [31:0] sc, fc;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    // Reference model state: how many consecutive cycles the memory has been waited on,
    // whether the trap has fired, and the event tallies.
    int          m_wait_run = 0;
    bit          m_to       = 0;
    logic [31:0] m_sc       = '0;
    logic [31:0] m_fc       = '0;

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 1'b0, idRs1: 5'd0, idRs2: 5'd0, idUsesRs1: 1'b0, idUsesRs2: 1'b0,
              exRs1: 5'd0, exRs2: 5'd0, exRd: 5'd0, exMemoryReadEnable: 1'b0,
              exPcUpdateTaken: 1'b0, memRd: 5'd0, memRegisterWriteEnable: 1'b0,
              memAccess: 1'b0, dmemReady: 1'b0, wbRd: 5'd0, wbRegisterWriteEnable: 1'b0};
        return s;
    endfunction

    function automatic logic [1:0] ref_fwd(input stim_t s, input logic [4:0] rs);
        if (s.memRegisterWriteEnable && s.memRd != 0 && s.memRd == rs) return 2'b10;
        if (s.wbRegisterWriteEnable && s.wbRd != 0 && s.wbRd == rs)    return 2'b01;
        return 2'b00;
    endfunction

    // One pipeline cycle: apply inputs, predict outputs, advance the model across the edge.
    task automatic step(input stim_t s);
        exp_t e;
        bit   mw, lu;
        @(posedge clock);
        #1;
        reset                      = s.rst;
        hif.idRs1                  = s.idRs1;
        hif.idRs2                  = s.idRs2;
        hif.idUsesRs1              = s.idUsesRs1;
        hif.idUsesRs2              = s.idUsesRs2;
        hif.exRs1                  = s.exRs1;
        hif.exRs2                  = s.exRs2;
        hif.exRd                   = s.exRd;
        hif.exMemoryReadEnable     = s.exMemoryReadEnable;
        hif.exPcUpdateTaken        = s.exPcUpdateTaken;
        hif.memRd                  = s.memRd;
        hif.memRegisterWriteEnable = s.memRegisterWriteEnable;
        hif.memAccess              = s.memAccess;
        hif.dmemReady              = s.dmemReady;
        hif.wbRd                   = s.wbRd;
        hif.wbRegisterWriteEnable  = s.wbRegisterWriteEnable;

        mw = s.memAccess && !s.dmemReady;
        lu = s.exMemoryReadEnable && s.exRd != 0 &&
             ((s.idUsesRs1 && s.idRs1 == s.exRd) || (s.idUsesRs2 && s.idRs2 == s.exRd));
        e = '0;
        if (!s.rst) begin
            e.fa = ref_fwd(s, s.exRs1);
            e.fb = ref_fwd(s, s.exRs2);
            if (m_to) begin
                {e.sf, e.sd, e.se, e.sm} = 4'hF;
                e.to = 1'b1;
            end else if (mw) begin
                {e.sf, e.sd, e.se, e.sm} = 4'hF;
            end else if (m_wait_run == 0) begin
                if (s.exPcUpdateTaken) begin
                    e.fd = 1'b1;
                    e.fe = 1'b1;
                end else if (lu) begin
                    e.sf = 1'b1;
                    e.sd = 1'b1;
                    e.fe = 1'b1;
                end
            end
`ifdef HAZARD_PERF_COUNTERS_EN
            e.sc = m_sc;
            e.fc = m_fc;
`endif
        end
        sb_q.push_back(e);

        if (s.rst) begin
            m_wait_run = 0;
            m_to       = 0;
            m_sc       = '0;
            m_fc       = '0;
        end else begin
            if (e.sf && m_sc != 32'hFFFF_FFFF)           m_sc = m_sc + 1;
            if ((e.fd || e.fe) && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
            if (!m_to) begin
                if (mw) begin
                    m_wait_run = m_wait_run + 1;
                    if (m_wait_run >= MEM_TIMEOUT) m_to = 1;
                end else begin
                    m_wait_run = 0;
                end
            end
        end
        cyc++;
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle on the falling edge.
    always @(negedge clock) begin
        if (sb_q.size() > 0) begin
            exp_t want, got;
            want = sb_q.pop_front();
            got  = '0;
            got.sf = hif.stallFetch;
            got.sd = hif.stallDecode;
            got.se = hif.stallExecute;
            got.sm = hif.stallMemory;
            got.fd = hif.flushDecode;
            got.fe = hif.flushExecute;
            got.fa = hif.forwardA;
            got.fb = hif.forwardB;
            got.to = hif.memTimeout;
`ifdef HAZARD_PERF_COUNTERS_EN
            got.sc = hif.stallCycleCount;
            got.fc = hif.flushCount;
`endif
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d got sf%b sd%b se%b sm%b fd%b fe%b fa%b fb%b to%b sc%0d fc%0d want sf%b sd%b se%b sm%b fd%b fe%b fa%b fb%b to%b sc%0d fc%0d",
                         cyc, got.sf, got.sd, got.se, got.sm, got.fd, got.fe, got.fa, got.fb, got.to, got.sc, got.fc,
                         want.sf, want.sd, want.se, want.sm, want.fd, want.fe, want.fa, want.fb, want.to, want.sc, want.fc);
            end
        end
    end

    initial begin
        stim_t       s;
        logic [4:0]  pool [4];
        pool  = '{5'd0, 5'd5, 5'd7, 5'd12};
        reset = 1'b1;

        // Reset: everything must read zero even with hazard-provoking inputs applied.
        s = idle(); s.rst = 1'b1;
        step(s);
        s.exMemoryReadEnable = 1; s.exRd = 5; s.idUsesRs1 = 1; s.idRs1 = 5;
        s.memAccess = 1; s.memRegisterWriteEnable = 1; s.memRd = 3; s.exRs1 = 3;
        step(s);
        step(idle());

        // Load-use bubble for exactly one cycle.
        s = idle(); s.exMemoryReadEnable = 1; s.exRd = 5; s.idUsesRs1 = 1; s.idRs1 = 5;
        step(s);
        step(idle());

        // Forwarding priority MEM > WB > regfile.
        s = idle(); s.exRs1 = 7; s.memRd = 7; s.wbRd = 7;
        s.memRegisterWriteEnable = 1; s.wbRegisterWriteEnable = 1;
        step(s);
        s.memRd = 0; step(s);
        s.exRs1 = 0; step(s);
        s = idle(); s.exRs2 = 9; s.wbRd = 9; s.wbRegisterWriteEnable = 1; step(s);

        // Redirect wins over load-use.
        s = idle(); s.exPcUpdateTaken = 1;
        s.exMemoryReadEnable = 1; s.exRd = 5; s.idUsesRs2 = 1; s.idRs2 = 5;
        step(s);
        step(idle());

        // Memory wait of three cycles then completion.
        s = idle(); s.memAccess = 1;
        repeat (3) step(s);
        s.dmemReady = 1; step(s);
        step(idle());

        // Timeout trap: sticky through dmemReady, cleared only by reset.
        s = idle(); s.memAccess = 1;
        repeat (6) step(s);
        s.dmemReady = 1; repeat (2) step(s);
        s = idle(); s.rst = 1; step(s);
        step(idle());

        // Reset in the middle of a wait, then load-use immediately after.
        s = idle(); s.memAccess = 1;
        repeat (2) step(s);
        s.rst = 1; step(s);
        s = idle(); s.exMemoryReadEnable = 1; s.exRd = 7; s.idUsesRs1 = 1; s.idRs1 = 7;
        step(s);
        // memAccess withdrawn mid-wait counts as completion.
        s = idle(); s.memAccess = 1; step(s);
        s.memAccess = 0; s.exPcUpdateTaken = 1; step(s);
        step(s);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            s.rst                    = ($urandom_range(0, 99) < 2) || (m_to && $urandom_range(0, 4) == 0);
            s.idRs1                  = pool[$urandom_range(0, 3)];
            s.idRs2                  = pool[$urandom_range(0, 3)];
            s.idUsesRs1              = 1'($urandom_range(0, 1));
            s.idUsesRs2              = 1'($urandom_range(0, 1));
            s.exRs1                  = pool[$urandom_range(0, 3)];
            s.exRs2                  = pool[$urandom_range(0, 3)];
            s.exRd                   = pool[$urandom_range(0, 3)];
            s.exMemoryReadEnable     = 1'($urandom_range(0, 1));
            s.exPcUpdateTaken        = ($urandom_range(0, 4) == 0);
            s.memRd                  = pool[$urandom_range(0, 3)];
            s.memRegisterWriteEnable = 1'($urandom_range(0, 1));
            s.memAccess              = ($urandom_range(0, 9) < 4);
            s.dmemReady              = ($urandom_range(0, 9) < 4);
            s.wbRd                   = pool[$urandom_range(0, 3)];
            s.wbRegisterWriteEnable  = 1'($urandom_range(0, 1));
            step(s);
        end

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clock);
        @(posedge clock);
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
